sift_frame_sequencer: RTL and testbench

Controller that sequences one full difference-of-Gaussians pass without manual switches or buttons. Steers incoming UART bytes into the sharper-image BRAM, then into the fuzzier-image BRAM. Once both are full, it pulses the DoG builder's start, waits for it to finish, then triggers the image transmitter. Sits in `top_level` between `uart_rx`, the two image BRAMs, `dog` and `send_img`, replacing the `sw[0]`/`btn` sequencing logic.

---
 rtl/sift_ctrl_pkg.sv | 30 +++
 rtl/rise_detect.sv | 38 +++
 rtl/sift_frame_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_sift_frame_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sift_ctrl_pkg
// Shared types and default constants for the SIFT frame sequencer.
//   seq_state_t   : 4-bit sequencer state, exported directly on state_o (LEDs)
//   DEF_*         : default values for the sequencer parameters
//   is_load_state : true in the two states that accept UART bytes
// ----------------------------------------------------------------------------
package sift_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_LOAD_SHARP = 4'd0,
        ST_LOAD_FUZZY = 4'd1,
        ST_SETTLE     = 4'd2,
        ST_DOG_START  = 4'd3,
        ST_DOG_RUN    = 4'd4,
        ST_TX_WAIT    = 4'd5,
        ST_TX_START   = 4'd6,
        ST_TX_RUN     = 4'd7,
        ST_ERROR      = 4'd8
    } seq_state_t;

    localparam int DEF_DIMENSION     = 64;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_ACK_TIMEOUT   = 1024;

    function automatic logic is_load_state(input seq_state_t s);
        return (s == ST_LOAD_SHARP) || (s == ST_LOAD_FUZZY);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector. The previous-level register resets to 0,
// and the detector only arms once the input has been sampled low, so a level
// that is already high when reset releases never produces a pulse.
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset
//   sig_i  in  : level to watch
//   rise_o out : one-cycle registered pulse per low->high transition
// ----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;
    logic rise_q;

    // Level history, arming after the first low sample, and the registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            armed_q <= armed_q | ~sig_i;
            rise_q  <= sig_i & ~prev_q & armed_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sift_frame_sequencer.sv
// ----------------------------------------------------------------------------
// sift_frame_sequencer
// Sequences one difference-of-Gaussians pass: loads the sharp frame, then the
// fuzzy frame from UART bytes, lets the BRAMs settle, starts the DoG builder,
// waits for it, then starts the image transmitter.
// Build option: SIFT_AUTO_TX_EN -- when defined, the transmitter starts as soon
// as DoG finishes and tx_req is ignored; otherwise TX_WAIT holds for tx_req.
// Ports:
//   clk        in  : clock
//   rst_in_n   in  : asynchronous active-low reset
//   rx_valid   in  : uart_rx valid level, one rising edge per byte
//   rx_addr    out : write address shared by both image BRAMs
//   we_sharp   out : write enable, sharp image BRAM
//   we_fuzzy   out : write enable, fuzzy image BRAM
//   dog_start  out : one-cycle start pulse to dog
//   dog_busy   in  : dog busy
//   tx_req     in  : transmit request (manual mode only)
//   tx_start   out : one-cycle start pulse to send_img
//   tx_busy    in  : send_img busy
//   state_o    out : current state encoding
//   dropped    out : sticky, byte arrived outside a load state
//   error      out : sticky, start acknowledge timed out
// ----------------------------------------------------------------------------
module sift_frame_sequencer
    import sift_ctrl_pkg::*;
#(
    parameter int DIMENSION     = DEF_DIMENSION,
    parameter int ADDR_W        = $clog2(DIMENSION * DIMENSION),
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_in_n,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] rx_addr,
    output logic              we_sharp,
    output logic              we_fuzzy,
    output logic              dog_start,
    input  logic              dog_busy,
    input  logic              tx_req,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [3:0]        state_o,
    output logic              dropped,
    output logic              error
);

    // One counter serves both the settle delay and the acknowledge timeout.
    localparam int CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(DIMENSION * DIMENSION - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

    seq_state_t        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              we_sharp_q,  we_sharp_d;
    logic              we_fuzzy_q,  we_fuzzy_d;
    logic              dog_start_q, dog_start_d;
    logic              tx_start_q,  tx_start_d;
    logic              dropped_q,   dropped_d;
    logic              error_q,     error_d;

    logic rx_rise_s;
    logic write_done_s;

`ifdef SIFT_AUTO_TX_EN
    logic unused_tx_req_s;
    assign unused_tx_req_s = tx_req;
`endif

    rise_detect u_rx_rise (
        .clk    (clk),
        .rst_n  (rst_in_n),
        .sig_i  (rx_valid),
        .rise_o (rx_rise_s)
    );

    // A write enable was high this cycle; the address advances at the next edge.
    assign write_done_s = we_sharp_q | we_fuzzy_q;

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        we_sharp_d  = 1'b0;
        we_fuzzy_d  = 1'b0;
        dog_start_d = 1'b0;
        tx_start_d  = 1'b0;
        error_d     = error_q;
        dropped_d   = dropped_q | (rx_rise_s & ~is_load_state(state_q));

        case (state_q)
            ST_LOAD_SHARP: begin
                we_sharp_d = rx_rise_s;
                if (write_done_s) begin
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = ADDR_ZERO;
                        state_d = ST_LOAD_FUZZY;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end

            ST_LOAD_FUZZY: begin
                we_fuzzy_d = rx_rise_s;
                if (write_done_s) begin
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = ADDR_ZERO;
                        cnt_d   = CNT_ZERO;
                        state_d = ST_SETTLE;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d       = CNT_ZERO;
                    dog_start_d = 1'b1;
                    state_d     = ST_DOG_START;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Counter is 0 in the pulse cycle; an ack on the final count still wins.
            ST_DOG_START: begin
                if (dog_busy) begin
                    state_d = ST_DOG_RUN;
                end else if (cnt_q == ACK_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DOG_RUN: begin
                if (!dog_busy) begin
                    state_d = ST_TX_WAIT;
                end else begin
                    state_d = ST_DOG_RUN;
                end
            end

            ST_TX_WAIT: begin
`ifdef SIFT_AUTO_TX_EN
                cnt_d      = CNT_ZERO;
                tx_start_d = 1'b1;
                state_d    = ST_TX_START;
`else
                if (tx_req) begin
                    cnt_d      = CNT_ZERO;
                    tx_start_d = 1'b1;
                    state_d    = ST_TX_START;
                end else begin
                    state_d = ST_TX_WAIT;
                end
`endif
            end

            ST_TX_START: begin
                if (tx_busy) begin
                    state_d = ST_TX_RUN;
                end else if (cnt_q == ACK_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_TX_RUN: begin
                if (!tx_busy) begin
                    addr_d  = ADDR_ZERO;
                    state_d = ST_LOAD_SHARP;
                end else begin
                    state_d = ST_TX_RUN;
                end
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            // An unreachable encoding is treated as a fault and parked in ERROR.
            default: begin
                error_d = 1'b1;
                state_d = ST_ERROR;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= ST_LOAD_SHARP;
            addr_q      <= ADDR_ZERO;
            cnt_q       <= CNT_ZERO;
            we_sharp_q  <= 1'b0;
            we_fuzzy_q  <= 1'b0;
            dog_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            dropped_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            we_sharp_q  <= we_sharp_d;
            we_fuzzy_q  <= we_fuzzy_d;
            dog_start_q <= dog_start_d;
            tx_start_q  <= tx_start_d;
            dropped_q   <= dropped_d;
            error_q     <= error_d;
        end
    end

    assign rx_addr   = addr_q;
    assign we_sharp  = we_sharp_q;
    assign we_fuzzy  = we_fuzzy_q;
    assign dog_start = dog_start_q;
    assign tx_start  = tx_start_q;
    assign state_o   = state_q;
    assign dropped   = dropped_q;
    assign error     = error_q;

endmodule

// File: tb/tb_sift_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sift_frame_sequencer
// Self-checking bench for sift_frame_sequencer at default parameters.
// Byte-load phases come from a table; every expected BRAM write is queued when
// the byte is driven and checked when the write enable appears. The DoG/TX
// handshake, timeout and reset corner cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_sift_frame_sequencer;

    logic        clk;
    logic        rst_in_n;
    logic        rx_valid;
    logic [13:0] rx_addr;
    logic        we_sharp;
    logic        we_fuzzy;
    logic        dog_start;
    logic        dog_busy;
    logic        tx_req;
    logic        tx_start;
    logic        tx_busy;
    logic [3:0]  state_o;
    logic        dropped;
    logic        error;

    sift_frame_sequencer dut (
        .clk       (clk),
        .rst_in_n  (rst_in_n),
        .rx_valid  (rx_valid),
        .rx_addr   (rx_addr),
        .we_sharp  (we_sharp),
        .we_fuzzy  (we_fuzzy),
        .dog_start (dog_start),
        .dog_busy  (dog_busy),
        .tx_req    (tx_req),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .state_o   (state_o),
        .dropped   (dropped),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sharp;
        logic [13:0] addr;
    } wr_t;

    typedef struct {
        int          n_bytes;
        int          mode;      // 0 sharp, 1 fuzzy
        logic [3:0]  exp_state;
        logic [13:0] exp_addr;
        logic        exp_dropped;
    } phase_t;

    phase_t      tbl [8];
    wr_t         sb [$];
    wr_t         mon_e;
    logic [13:0] ptr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_count = 0;
    int dog_starts = 0;
    int tx_starts = 0;
    int last_we_cyc = 0;
    int dog_start_cyc = 0;
    int tx_start_cyc = 0;
    int error_cyc = 0;
    logic err_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle counter, advanced on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pop on every write, pulse bookkeeping.
    always @(negedge clk) begin
        if (we_sharp || we_fuzzy) begin
            we_count    <= we_count + 1;
            last_we_cyc <= cyc;
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(we_sharp | we_fuzzy), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("we_sharp", 32'(we_sharp), 32'(mon_e.sharp));
                check("we_fuzzy", 32'(we_fuzzy), 32'(!mon_e.sharp));
                check("we_addr",  32'(rx_addr),  32'(mon_e.addr));
            end
        end
        if (dog_start) begin
            dog_starts    <= dog_starts + 1;
            dog_start_cyc <= cyc;
        end
        if (tx_start) begin
            tx_starts    <= tx_starts + 1;
            tx_start_cyc <= cyc;
        end
        if (error && !err_seen) begin
            err_seen  <= 1'b1;
            error_cyc <= cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive one byte strobe (2 cycles); modes 0/1 expect a write, 2 expects none.
    task automatic send_byte(input int mode);
        wr_t w;
        step();
        rx_valid = 1'b1;
        if (mode != 2) begin
            w.sharp = (mode == 0);
            w.addr  = ptr;
            sb.push_back(w);
            ptr = (ptr == 14'd4095) ? 14'd0 : ptr + 14'd1;
        end
        step();
        rx_valid = 1'b0;
    endtask

    task automatic run_phases(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) begin
            for (int b = 0; b < tbl[p].n_bytes; b++) send_byte(tbl[p].mode);
            step();
            step();
            check($sformatf("phase%0d_state", p),   32'(state_o), 32'(tbl[p].exp_state));
            check($sformatf("phase%0d_addr", p),    32'(rx_addr), 32'(tbl[p].exp_addr));
            check($sformatf("phase%0d_dropped", p), 32'(dropped), 32'(tbl[p].exp_dropped));
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({rx_addr, we_sharp, we_fuzzy, dog_start, tx_start,
                         state_o, dropped, error}), 32'd0);
    endtask

    task automatic wait_dog_start(input int ds0);
        int i;
        i = 0;
        while (dog_starts == ds0 && i < 50) begin
            step();
            i++;
        end
        check("dog_start_seen", 32'(dog_starts - ds0), 32'd1);
    endtask

    // DoG + TX handshake after a full frame pair, including a dropped byte.
    task automatic run_flow();
        int ds0, ts0, s, k, i, we0;
        ds0 = dog_starts;
        ts0 = tx_starts;
        wait_dog_start(ds0);
        s = dog_start_cyc;
        check("dog_start_latency", 32'(s - last_we_cyc), 32'd5);
        step();
        check("dog_start_width", 32'(dog_start), 32'd0);
        step();
        dog_busy = 1'b1;
        step();
        step();
        check("dog_run_state", 32'(state_o), 32'd4);
        we0 = we_count;
        send_byte(2);
        step();
        step();
        check("drop_in_dog_run", 32'(dropped), 32'd1);
        check("drop_addr_kept",  32'(rx_addr), 32'd0);
        check("drop_no_write",   32'(we_count - we0), 32'd0);
        check("drop_state",      32'(state_o), 32'd4);
        repeat (93) step();
        dog_busy = 1'b0;
        k = cyc;
        i = 0;
`ifdef SIFT_AUTO_TX_EN
        while (tx_starts == ts0 && i < 20) begin
            step();
            i++;
        end
        check("tx_start_seen",    32'(tx_starts - ts0), 32'd1);
        check("tx_start_latency", 32'(tx_start_cyc - k), 32'd2);
`else
        repeat (50) step();
        check("tx_hold_without_req", 32'(tx_starts - ts0), 32'd0);
        check("tx_wait_state",       32'(state_o), 32'd5);
        tx_req = 1'b1;
        k = cyc;
        while (tx_starts == ts0 && i < 20) begin
            step();
            i++;
        end
        check("tx_start_seen",    32'(tx_starts - ts0), 32'd1);
        check("tx_start_latency", 32'(tx_start_cyc - k), 32'd1);
`endif
        step();
        tx_busy = 1'b1;
        repeat (30) step();
        tx_busy = 1'b0;
        step();
        step();
        check("back_to_load_sharp", 32'(state_o), 32'd0);
        check("addr_after_tx",      32'(rx_addr), 32'd0);
        check("tx_start_once",      32'(tx_starts - ts0), 32'd1);
        check("dog_start_once",     32'(dog_starts - ds0), 32'd1);
        tx_req = 1'b0;
    endtask

    initial begin
        int ds0, s, i, we0;
        tbl[0] = '{4095, 0, 4'd0, 14'd4095, 1'b0};
        tbl[1] = '{1,    0, 4'd1, 14'd0,    1'b0};
        tbl[2] = '{4095, 1, 4'd1, 14'd4095, 1'b0};
        tbl[3] = '{1,    1, 4'd2, 14'd0,    1'b0};
        tbl[4] = '{4096, 0, 4'd1, 14'd0,    1'b0};
        tbl[5] = '{2000, 1, 4'd1, 14'd2000, 1'b0};
        tbl[6] = '{4096, 0, 4'd1, 14'd0,    1'b0};
        tbl[7] = '{4096, 1, 4'd2, 14'd0,    1'b0};

        rst_in_n = 1'b0;
        rx_valid = 1'b1;
        dog_busy = 1'b0;
        tx_req   = 1'b0;
        tx_busy  = 1'b0;
        ptr      = 14'd0;

        // rx_valid high across reset release must not count as a byte.
        step();
        check_all_zero("reset_state");
        step();
        rst_in_n = 1'b1;
        repeat (5) step();
        check("no_write_high_at_reset", 32'(we_count), 32'd0);
        rx_valid = 1'b0;
        step();
        run_phases(0, 3);
        run_flow();

        // Fresh start, then a reset in the middle of the fuzzy frame.
        rst_in_n = 1'b0;
        #1;
        check_all_zero("reset_after_flow");
        sb.delete();
        ptr = 14'd0;
        step();
        rst_in_n = 1'b1;
        step();
        run_phases(4, 5);
        rst_in_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        sb.delete();
        ptr = 14'd0;
        step();
        rst_in_n = 1'b1;
        step();
        run_phases(6, 7);

        // DoG never acknowledges: timeout into ERROR.
        ds0 = dog_starts;
        wait_dog_start(ds0);
        s = dog_start_cyc;
        i = 0;
        while (!err_seen && i < 1100) begin
            step();
            i++;
        end
        check("error_set",        32'(err_seen), 32'd1);
        check("timeout_latency",  32'(error_cyc - s), 32'd1024);
        check("error_state",      32'(state_o), 32'd8);
        check("dropped_before",   32'(dropped), 32'd0);
        we0 = we_count;
        for (int b = 0; b < 3; b++) send_byte(2);
        step();
        step();
        check("drop_in_error",     32'(dropped), 32'd1);
        check("error_no_write",    32'(we_count - we0), 32'd0);
        check("error_absorbing",   32'(state_o), 32'd8);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
